// File: rtl/hc595_pkg.sv
// Shared types and helpers for the 74HC595 chain driver.
package hc595_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHIFT = 2'd2,
        LATCH = 2'd3
    } state_t;

    localparam int unsigned BITS_PER_BYTE = 8;

    // Width of a counter that must hold 0..n-1; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        int unsigned w;
        w = 1;
        if (n > 2) begin
            w = int'($clog2(n));
        end
        return w;
    endfunction

endpackage

// File: rtl/hc595_pwm_oe.sv
// Brightness PWM for the 74HC595 output enable. Outputs stay dark until the
// first completed frame has been latched into the chain.
module hc595_pwm_oe #(
    parameter int unsigned BRIGHT_W = 4
) (
    input  logic                clk,
    input  logic                nreset,
    input  logic                set_lit,
    input  logic [BRIGHT_W-1:0] brightness,
    output logic                noe
);

    logic [BRIGHT_W-1:0] pwm_cnt;
    logic                lit;

    // Free-running PWM counter, wraps naturally at 2^BRIGHT_W-1.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    // Lit flag: set once valid data has been latched, cleared only by reset.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            lit <= 1'b0;
        end else if (set_lit) begin
            lit <= 1'b1;
        end
    end

    // Registered active-low enable; brightness 0 keeps the outputs dark.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            noe <= 1'b1;
        end else begin
            noe <= ~(lit && (pwm_cnt < brightness));
        end
    end

endmodule

// File: rtl/hc595_chain_driver.sv
// Serialises frame bytes MSB-first into a cascade of 74HC595 shift registers,
// pulses the storage latch, and shares the data line with the stepper DIR bit
// while idle.
module hc595_chain_driver
    import hc595_pkg::*;
#(
    parameter int unsigned CHAIN_BYTES = 1,
    parameter int unsigned SCLK_DIV    = 2,
    parameter int unsigned BRIGHT_W    = 4
) (
    input  logic                clk,
    input  logic                nreset,
    input  logic                frame_start,
    input  logic [7:0]          byte_in,
    input  logic                byte_valid,
    output logic                byte_req,
    input  logic                dir_in,
    input  logic [BRIGHT_W-1:0] brightness,
    output logic                sclk,
    output logic                sdat,
    output logic                latch,
    output logic                noe,
    output logic                busy,
    output logic                frame_done,
    output logic                overrun
);

    localparam int unsigned BYTE_W = cnt_w(CHAIN_BYTES);
    localparam int unsigned DIV_W  = cnt_w(SCLK_DIV);
    localparam int unsigned BIT_W  = cnt_w(BITS_PER_BYTE);

    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(CHAIN_BYTES - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCLK_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(BITS_PER_BYTE - 1);

    state_t                   state;
    logic [BYTE_W-1:0]        byte_cnt;
    logic [BIT_W-1:0]         bit_cnt;
    logic [DIV_W-1:0]         div_cnt;
    logic [BITS_PER_BYTE-1:0] shreg;
    logic                     set_lit;

    // The shared line carries DIR while idle; otherwise the current bit,
    // which after the last shift still holds bit 0 through LATCH.
    assign sdat = (state == IDLE) ? dir_in : shreg[BITS_PER_BYTE-1];

    // Last LATCH cycle: the chain outputs now hold a complete frame.
    assign set_lit = (state == LATCH) && (div_cnt == DIV_LAST);

    // Serialiser FSM with registered strobes, divider and counters.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state      <= IDLE;
            byte_cnt   <= '0;
            bit_cnt    <= '0;
            div_cnt    <= '0;
            shreg      <= '0;
            sclk       <= 1'b0;
            latch      <= 1'b0;
            busy       <= 1'b0;
            byte_req   <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            overrun    <= 1'b0;
            if (frame_start && (state != IDLE)) begin
                overrun <= 1'b1;
            end

            case (state)
                IDLE: begin
                    sclk  <= 1'b0;
                    latch <= 1'b0;
                    if (frame_start) begin
                        state    <= FETCH;
                        byte_cnt <= '0;
                        busy     <= 1'b1;
                        byte_req <= 1'b1;
                    end
                end

                FETCH: begin
                    if (byte_valid) begin
                        shreg    <= byte_in;
                        byte_req <= 1'b0;
                        state    <= SHIFT;
                        sclk     <= 1'b0;
                        div_cnt  <= '0;
                        bit_cnt  <= '0;
                    end
                end

                SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (!sclk) begin
                            sclk <= 1'b1;
                        end else begin
                            // Falling edge: the only point where sdat may move.
                            sclk <= 1'b0;
                            if (bit_cnt == BIT_LAST) begin
                                if (byte_cnt == BYTE_LAST) begin
                                    state <= LATCH;
                                    latch <= 1'b1;
                                end else begin
                                    byte_cnt <= byte_cnt + 1'b1;
                                    state    <= FETCH;
                                    byte_req <= 1'b1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                                shreg   <= {shreg[BITS_PER_BYTE-2:0], 1'b0};
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                LATCH: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt    <= '0;
                        latch      <= 1'b0;
                        state      <= IDLE;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    hc595_pwm_oe #(
        .BRIGHT_W(BRIGHT_W)
    ) u_pwm_oe (
        .clk       (clk),
        .nreset    (nreset),
        .set_lit   (set_lit),
        .brightness(brightness),
        .noe       (noe)
    );

endmodule

// File: tb/tb_hc595_chain_driver.sv
// Self-checking bench for hc595_chain_driver (CHAIN_BYTES=2, SCLK_DIV=2, BRIGHT_W=4).
module tb_hc595_chain_driver;

    logic       clk = 1'b0;
    logic       nreset = 1'b1;
    logic       frame_start = 1'b0;
    logic [7:0] byte_in = 8'h00;
    logic       byte_valid = 1'b0;
    logic       byte_req;
    logic       dir_in = 1'b0;
    logic [3:0] brightness = 4'd4;
    logic       sclk, sdat, latch, noe, busy, frame_done, overrun;

    int total = 0;
    int bad   = 0;

    logic [7:0] src[$];
    logic       sb[$];
    bit         pending = 1'b0;
    logic       sclk_d = 1'b0;

    hc595_chain_driver #(
        .CHAIN_BYTES(2),
        .SCLK_DIV   (2),
        .BRIGHT_W   (4)
    ) dut (
        .clk        (clk),
        .nreset     (nreset),
        .frame_start(frame_start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_req   (byte_req),
        .dir_in     (dir_in),
        .brightness (brightness),
        .sclk       (sclk),
        .sdat       (sdat),
        .latch      (latch),
        .noe        (noe),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // Upstream source plus scoreboard: expected bits pushed when a byte is
    // handed over, popped on every observed sclk rising edge.
    always @(negedge clk) begin
        logic [7:0] cur;
        logic       exp_bit;
        if (pending) begin
            cur     = src.pop_front();
            pending = 1'b0;
        end
        byte_in = (src.size() > 0) ? src[0] : 8'h00;
        if (byte_req && byte_valid && nreset && (src.size() > 0)) begin
            pending = 1'b1;
            cur = src[0];
            for (int i = 7; i >= 0; i--) sb.push_back(cur[i]);
        end
        if (sclk && !sclk_d) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sdat_sb unexpected sclk edge got=%b exp=none", sdat);
            end else begin
                exp_bit = sb.pop_front();
                if (sdat !== exp_bit) begin
                    bad++;
                    $display("FAIL sdat_sb got=%b exp=%b", sdat, exp_bit);
                end
            end
        end
        sclk_d = sclk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        int lows;
        #3 nreset = 1'b0;
        #1;
        total++;
        if ({sclk, latch, noe, busy, byte_req, frame_done, overrun} !== 7'b0010000) begin
            bad++;
            $display("FAIL reset_outputs got=%b exp=%b",
                     {sclk, latch, noe, busy, byte_req, frame_done, overrun}, 7'b0010000);
        end
        total++;
        if (sdat !== dir_in) begin
            bad++;
            $display("FAIL reset_sdat got=%b exp=%b", sdat, dir_in);
        end
        repeat (3) @(posedge clk);
        #1 nreset = 1'b1;
        lows = 0;
        for (int c = 0; c < 16; c++) begin
            @(posedge clk); #1;
            if (noe === 1'b0) lows++;
        end
        total++;
        if (lows != 0) begin
            bad++;
            $display("FAIL unlit_noe low_cycles got=%0d exp=0", lows);
        end
    endtask

    task automatic test_idle_dir();
        logic [2:0] pat;
        pat = 3'b010;
        byte_valid = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            dir_in = pat[i];
            #1;
            total++;
            if ({sdat, sclk, latch, busy} !== {pat[i], 3'b000}) begin
                bad++;
                $display("FAIL idle_dir got=%b exp=%b", {sdat, sclk, latch, busy}, {pat[i], 3'b000});
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_frame();
        logic e;
        byte_valid = 1'b1;
        src.push_back(8'hA5);
        src.push_back(8'h3C);
        @(posedge clk); #1;
        frame_start = 1'b1;
        for (int c = 1; c <= 72; c++) begin
            @(posedge clk); #1;
            if (c == 1) frame_start = 1'b0;
            e = (c >= 1 && c <= 68);
            total++;
            if (busy !== e) begin bad++; $display("FAIL frame_busy c=%0d got=%b exp=%b", c, busy, e); end
            e = (c == 67 || c == 68);
            total++;
            if (latch !== e) begin bad++; $display("FAIL frame_latch c=%0d got=%b exp=%b", c, latch, e); end
            e = (c == 69);
            total++;
            if (frame_done !== e) begin bad++; $display("FAIL frame_done c=%0d got=%b exp=%b", c, frame_done, e); end
            if (c == 1 || c == 34 || c >= 67) begin
                total++;
                if (sclk !== 1'b0) begin bad++; $display("FAIL frame_sclk_low c=%0d got=%b exp=0", c, sclk); end
            end
        end
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL frame_bits_left got=%0d exp=0", sb.size()); end
    endtask

    task automatic test_stall();
        logic e;
        byte_valid = 1'b0;
        src.push_back(8'h5A);
        src.push_back(8'hC3);
        @(posedge clk); #1;
        frame_start = 1'b1;
        for (int c = 1; c <= 82; c++) begin
            @(posedge clk); #1;
            if (c == 1) frame_start = 1'b0;
            if (c <= 10) begin
                total++;
                if ({byte_req, sclk} !== 2'b10) begin
                    bad++;
                    $display("FAIL stall_req_sclk c=%0d got=%b exp=10", c, {byte_req, sclk});
                end
            end
            if (c == 11) byte_valid = 1'b1;
            e = (c == 79);
            total++;
            if (frame_done !== e) begin bad++; $display("FAIL stall_done c=%0d got=%b exp=%b", c, frame_done, e); end
            e = (c == 77 || c == 78);
            total++;
            if (latch !== e) begin bad++; $display("FAIL stall_latch c=%0d got=%b exp=%b", c, latch, e); end
        end
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL stall_bits_left got=%0d exp=0", sb.size()); end
    endtask

    task automatic test_reject();
        logic e;
        byte_valid = 1'b1;
        src.push_back(8'hFF);
        src.push_back(8'h00);
        @(posedge clk); #1;
        frame_start = 1'b1;
        for (int c = 1; c <= 80; c++) begin
            @(posedge clk); #1;
            if (c == 1 || c == 21) frame_start = 1'b0;
            if (c == 20) frame_start = 1'b1;
            e = (c == 21);
            total++;
            if (overrun !== e) begin bad++; $display("FAIL reject_overrun c=%0d got=%b exp=%b", c, overrun, e); end
            e = (c == 69);
            total++;
            if (frame_done !== e) begin bad++; $display("FAIL reject_done c=%0d got=%b exp=%b", c, frame_done, e); end
            e = (c <= 68);
            total++;
            if (busy !== e) begin bad++; $display("FAIL reject_busy c=%0d got=%b exp=%b", c, busy, e); end
        end
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL reject_bits_left got=%0d exp=0", sb.size()); end
    endtask

    task automatic test_back_to_back();
        logic e;
        byte_valid = 1'b1;
        src.push_back(8'h01);
        src.push_back(8'h80);
        src.push_back(8'h7E);
        src.push_back(8'h81);
        @(posedge clk); #1;
        frame_start = 1'b1;
        for (int c = 1; c <= 145; c++) begin
            @(posedge clk); #1;
            if (c == 70) frame_start = 1'b0;
            e = (c <= 68) || (c >= 70 && c <= 137);
            total++;
            if (busy !== e) begin bad++; $display("FAIL b2b_busy c=%0d got=%b exp=%b", c, busy, e); end
            e = (c == 69 || c == 138);
            total++;
            if (frame_done !== e) begin bad++; $display("FAIL b2b_done c=%0d got=%b exp=%b", c, frame_done, e); end
        end
        total++;
        if (sb.size() != 0 || src.size() != 0) begin
            bad++;
            $display("FAIL b2b_leftover got=%0d/%0d exp=0/0", sb.size(), src.size());
        end
    endtask

    task automatic test_pwm();
        logic [3:0] levels [3];
        int         exp_lows [3];
        int         lows;
        levels[0] = 4'd4;  exp_lows[0] = 4;
        levels[1] = 4'd0;  exp_lows[1] = 0;
        levels[2] = 4'd15; exp_lows[2] = 15;
        for (int k = 0; k < 3; k++) begin
            brightness = levels[k];
            repeat (3) @(posedge clk);
            #1;
            lows = 0;
            for (int c = 0; c < 16; c++) begin
                @(posedge clk); #1;
                if (noe === 1'b0) lows++;
            end
            total++;
            if (lows != exp_lows[k]) begin
                bad++;
                $display("FAIL pwm_b%0d low_cycles got=%0d exp=%0d", levels[k], lows, exp_lows[k]);
            end
        end
        brightness = 4'd4;
    endtask

    task automatic test_reset_mid();
        byte_valid = 1'b1;
        src.push_back(8'h12);
        src.push_back(8'h34);
        @(posedge clk); #1;
        frame_start = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            if (c == 1) frame_start = 1'b0;
        end
        nreset = 1'b0;
        #1;
        total++;
        if ({sclk, latch, noe, busy, byte_req, frame_done, overrun} !== 7'b0010000) begin
            bad++;
            $display("FAIL midreset_outputs got=%b exp=%b",
                     {sclk, latch, noe, busy, byte_req, frame_done, overrun}, 7'b0010000);
        end
        total++;
        if (sdat !== dir_in) begin bad++; $display("FAIL midreset_sdat got=%b exp=%b", sdat, dir_in); end
        src.delete();
        sb.delete();
        pending = 1'b0;
        repeat (4) @(posedge clk);
        #1 nreset = 1'b1;
        for (int c = 0; c < 80; c++) begin
            @(posedge clk); #1;
            total++;
            if ({latch, noe, busy} !== 3'b010) begin
                bad++;
                $display("FAIL midreset_after c=%0d got=%b exp=010", c, {latch, noe, busy});
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle_dir();
        test_frame();
        test_stall();
        test_reject();
        test_back_to_back();
        test_pwm();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hc595_chain_driver.md
Name: hc595_chain_driver

Overview:
- Downstream output stage that consumes bytes from the pixel shift-register path.
- Serialises them MSB-first into a chain of 74HC595 devices, then pulses the storage latch.
- Drives nOE with a brightness PWM.
- Shares the data line with the stepper direction bit: when idle, sdat carries dir_in so the stepper driver samples direction on that line.

Parameters:
- CHAIN_BYTES, 1, number of cascaded 74HC595 devices (bytes per frame), >=1
- SCLK_DIV, 2, clk cycles per sclk half-period, >=1
- BRIGHT_W, 4, width of brightness value and PWM counter

Ports:
- clk  in  1  system clock, all logic on rising edge
- nreset  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle request to send one frame
- byte_in  in  8  next frame byte from upstream shift register
- byte_valid  in  1  byte_in valid; captured only while byte_req=1
- byte_req  out  1  requesting next byte; held until byte_valid seen
- dir_in  in  1  stepper direction, driven onto sdat while idle
- brightness  in  BRIGHT_W  nOE duty; 0 = dark
- sclk  out  1  74HC595 SRCLK
- sdat  out  1  74HC595 SER / stepper DIR shared line
- latch  out  1  74HC595 RCLK
- noe  out  1  74HC595 nOE, active low
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse on frame completion
- overrun  out  1  one-cycle pulse when frame_start is rejected

Behaviour:
- Reset (asynchronous, immediate) values:
  - sclk=0, latch=0, noe=1, busy=0, byte_req=0, frame_done=0, overrun=0.
  - State=IDLE, byte counter=0, bit counter=0, divider=0, PWM counter=0, lit flag=0.
  - sdat follows dir_in.
- States: IDLE, FETCH, SHIFT, LATCH.
- IDLE:
  - sdat=dir_in (combinational mux); sclk=0; latch=0.
  - frame_start=1 → FETCH next cycle; byte counter cleared; busy=1 and byte_req=1 from the next cycle.
- FETCH:
  - byte_req=1.
  - On the cycle byte_valid=1: capture byte_in, byte_req=0, go SHIFT.
  - byte_valid may stay low indefinitely; the block waits and sclk stays low.
- SHIFT:
  - 8 bits, MSB first.
  - Per bit: sdat = current bit, sclk low for SCLK_DIV cycles, then high for SCLK_DIV cycles.
  - sdat changes only while sclk is low, and is stable across the rising edge.
  - Bit 7 is presented on the first SHIFT cycle.
  - Exactly 16*SCLK_DIV cycles per byte.
  - After bit 0 high-phase: if byte counter < CHAIN_BYTES-1, increment and go FETCH; else go LATCH.
- LATCH:
  - sclk=0; latch=1 for SCLK_DIV cycles; sdat holds last bit.
  - Then go IDLE with frame_done=1 for one cycle, busy=0, lit flag set.
- busy=1 in every FETCH/SHIFT/LATCH cycle.
- A frame_start in the same cycle as frame_done (first IDLE cycle) is accepted.
- frame_start while busy: ignored, no state change; overrun=1 next cycle for one cycle.
- byte_valid while byte_req=0: ignored.
- Latency with byte_valid tied high, frame_start sampled at cycle 0:
  - frame_done at cycle CHAIN_BYTES*(1+16*SCLK_DIV)+SCLK_DIV+1.
- PWM:
  - BRIGHT_W-bit counter free-running from reset, wraps 2^BRIGHT_W-1 → 0.
  - noe = ~(lit && pwm_cnt < brightness), registered.
  - brightness=0 → noe constantly 1; max value → low (2^W-1)/2^W of the time.
  - brightness changes take effect on the next counter compare.
  - noe keeps running during frames; the 74HC595 latch isolates its outputs.
- Reset mid-frame: partial data is never latched (latch stays 0); the lit flag clears, so noe=1 until the next completed frame.

Decomposition:
- Shared package hc595_pkg:
  - State enum (IDLE, FETCH, SHIFT, LATCH, 2-bit).
  - BITS_PER_BYTE=8 localparam.
  - Counter-width helper function (clog2).
- One natural sub-module, hc595_pwm_oe: PWM counter, compare, lit gating and registered noe.
- Serialiser FSM, divider and counters stay in the top module.

Test Plan:
- Two-byte frame. Setup: CHAIN_BYTES=2, SCLK_DIV=2, byte_valid tied high, bytes 0xA5 then 0x3C, frame_start at cycle 0.
  - sdat sampled on the 16 sclk rising edges = 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0.
  - latch high cycles 67-68; frame_done at cycle 69; busy high cycles 1-68.
- Upstream stall: byte_valid held low 10 cycles in first FETCH → byte_req high those 10 cycles; sclk stays 0; frame_done delayed exactly 10 cycles (79).
- Rejected start: frame_start at cycle 20 of a busy frame → overrun pulse at 21; frame data and frame_done timing unchanged; no second frame.
- Back-to-back frames: frame_start held high → new frame accepted in the frame_done cycle; busy low for 1 cycle only.
- Idle direction: in IDLE toggle dir_in 0→1→0 → sdat follows in the same cycle; sclk and latch stay 0.
- PWM and reset:
  - BRIGHT_W=4, brightness=4, after one frame → noe low 4 of every 16 cycles; brightness=0 → noe always 1.
  - Assert nreset at cycle 30 of a frame → all outputs at reset values immediately, latch never pulses, noe=1.
